// File: rtl/inst_sequencer.sv
// inst_sequencer: streams a small stored program of PE instructions, one per
// cycle, to the PE control decoder, and counts write-backs still in flight.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   prog_we, prog_addr, prog_data     program write (accepted in IDLE only)
//   start                             begin a run from address 0 (IDLE only)
//   stall                             hold issue for this cycle
//   wb_v                              write-back return from the decoder
//   inst_v, inst                      issued instruction
//   busy, done                        run status; done pulses for one cycle
//   pending                           write-backs issued and not yet returned
//   err                               sticky: a return arrived with none pending
module inst_sequencer #(
    parameter int INST_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [INST_WIDTH-1:0] prog_data,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  wb_v,
    output logic                  inst_v,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pending,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // pc carries one extra bit so that running past the last entry is
    // visible as pc == DEPTH instead of wrapping back to address 0.
    localparam logic [ADDR_W:0] PC_END = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      OP_HALT = 3'b100;

    logic [INST_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_W:0]       pc_q, pc_d;
    logic                  inst_v_q, inst_v_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  busy_q, done_q;
    logic [CNT_W-1:0]      pend_q, pend_d;
    logic                  err_q, err_d;

    logic [INST_WIDTH-1:0] rd_data;
    logic                  rd_halt;
    logic                  wb_issue;

    assign rd_data  = mem_q[pc_q[ADDR_W-1:0]];
    assign rd_halt  = (rd_data[26:24] == OP_HALT);
    assign wb_issue = inst_v_q & inst_q[INST_WIDTH-1];

    // Program store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == IDLE)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        inst_v_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                if (pc_q == PC_END) begin
                    state_d = DRAIN;
                end else if (!stall) begin
                    if (rd_halt) begin
                        state_d = DRAIN;
                    end else begin
                        inst_d   = rd_data;
                        inst_v_d = 1'b1;
                        pc_d     = pc_q + (ADDR_W + 1)'(1);
                    end
                end
            end
            DRAIN: begin
                if (pend_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // An issue and a return in the same cycle cancel out; a return with
    // nothing outstanding leaves the count at zero and flags the error.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (wb_issue && !wb_v) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (!wb_issue && wb_v) begin
            if (pend_q == '0) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            inst_v_q <= 1'b0;
            inst_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_v_q <= inst_v_d;
            inst_q   <= inst_d;
            busy_q   <= (state_d == RUN) || (state_d == DRAIN);
            done_q   <= (state_d == DONE);
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign inst_v  = inst_v_q;
    assign inst    = inst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pending = pend_q;
    assign err     = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: directed and randomized runs compared each cycle
// against a transaction-level model of the sequencer.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [63:0] prog_data;
    logic        start;
    logic        stall;
    logic        wb_v;
    logic        inst_v;
    logic [63:0] inst;
    logic        busy;
    logic        done;
    logic [4:0]  pending;
    logic        err;

    int checks = 0;
    int errors = 0;

    inst_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .stall     (stall),
        .wb_v      (wb_v),
        .inst_v    (inst_v),
        .inst      (inst),
        .busy      (busy),
        .done      (done),
        .pending   (pending),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 issuing, 2 draining, 3 finished.
    logic [63:0] m_prog [16];
    int          m_mode;
    int          m_next;
    logic        m_iv;
    logic [63:0] m_inst;
    int          m_pend;
    logic        m_err;

    int cyc = 0;
    int ret_q[$];
    bit auto_wb = 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk("inst_v", 64'(inst_v), 64'(m_iv));
        chk("inst", inst, m_inst);
        chk("busy", 64'(busy), 64'(m_mode == 1 || m_mode == 2));
        chk("done", 64'(done), 64'(m_mode == 3));
        chk("pending", 64'(pending), 64'(m_pend));
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_next = 0;
        m_iv   = 1'b0;
        m_inst = '0;
        m_pend = 0;
        m_err  = 1'b0;
        ret_q.delete();
    endtask

    task automatic model_edge(input logic we, input logic [3:0] a,
                              input logic [63:0] d, input logic st,
                              input logic stl, input logic wb);
        int   old_pend;
        logic inc;
        logic iv_new;
        old_pend = m_pend;
        inc      = m_iv && m_inst[63];
        if (inc && !wb) m_pend++;
        else if (!inc && wb) begin
            if (m_pend == 0) m_err = 1'b1;
            else m_pend--;
        end
        iv_new = 1'b0;
        case (m_mode)
            0: begin
                if (we) m_prog[a] = d;
                if (st) begin
                    m_mode = 1;
                    m_next = 0;
                end
            end
            1: begin
                if (m_next == 16) m_mode = 2;
                else if (!stl) begin
                    if (m_prog[m_next][26:24] == 3'b100) m_mode = 2;
                    else begin
                        m_inst = m_prog[m_next];
                        iv_new = 1'b1;
                        m_next++;
                    end
                end
            end
            2: if (old_pend == 0) m_mode = 3;
            default: m_mode = 0;
        endcase
        m_iv = iv_new;
    endtask

    // One clock: drive inputs, advance DUT and model, compare.
    task automatic step(input logic we, input logic [3:0] a,
                        input logic [63:0] d, input logic st,
                        input logic stl, input logic wbx);
        logic due;
        due = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            due = 1'b1;
            void'(ret_q.pop_front());
        end
        prog_we   = we;
        prog_addr = a;
        prog_data = d;
        start     = st;
        stall     = stl;
        wb_v      = wbx | due;
        @(posedge clk);
        cyc++;
        model_edge(we, a, d, st, stl, wbx | due);
        if (auto_wb && m_iv && m_inst[63]) ret_q.push_back(cyc + 5);
        #1;
        check_all();
    endtask

    task automatic idle_step();
        step(1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] mk(input logic wb, input logic [2:0] op);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[63] = wb;
        v[26:24] = op;
        return v;
    endfunction

    function automatic logic [2:0] rand_op();
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        if (op >= 3'd4) op = op + 3'd1;
        return op;
    endfunction

    task automatic load(input logic [63:0] p [16], input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 4'(i), p[i], 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Finish a run; optionally poke prog_we in RUN and start in DRAIN.
    task automatic run_rest(input int stall_pct, input bit pokes);
        int  n;
        logic st, we, stl;
        n = 0;
        while (m_mode != 0 && n < 300) begin
            st  = pokes && m_mode == 2;
            we  = pokes && m_mode == 1;
            stl = ($urandom_range(0, 99) < stall_pct);
            step(we, 4'd0, {$urandom, $urandom}, st, stl, 1'b0);
            n++;
        end
        checks++;
        assert (n < 300) else begin
            errors++;
            $error("FAIL run_timeout got=%0d exp=<300", n);
        end
    endtask

    task automatic run(input int stall_pct, input bit pokes);
        step(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        run_rest(stall_pct, pokes);
    endtask

    logic [63:0] p [16];
    int          k;

    initial begin
        prog_we = 0; prog_addr = 0; prog_data = 0;
        start = 0; stall = 0; wb_v = 0;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) m_prog[i] = '0;
        #12;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        // Fill all entries with HALT so unloaded memory is defined.
        for (int i = 0; i < 16; i++) p[i] = mk(1'b0, 3'b100);
        load(p, 16);

        // ADD, MUL(wb), HALT; returns five cycles after issue.
        p[0] = mk(1'b0, 3'b001);
        p[1] = mk(1'b1, 3'b011);
        p[2] = mk(1'b0, 3'b100);
        load(p, 3);
        run(0, 0);
        idle_step();

        // Same program with a stall two cycles after start.
        step(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        idle_step();
        step(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        run_rest(0, 0);

        // Sixteen write-backs held back until the run drains.
        for (int i = 0; i < 16; i++) p[i] = mk(1'b1, rand_op());
        load(p, 16);
        auto_wb = 0;
        step(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (m_mode != 2 && k < 100) begin
            idle_step();
            k++;
        end
        idle_step();
        chk("pending_full", 64'(pending), 64'd16);
        chk("no_wrap_iv", 64'(inst_v), 64'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        auto_wb = 1;
        run_rest(0, 0);

        // Back-to-back wb issues collide with their own returns.
        run(0, 0);

        // Spurious return while idle.
        step(1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        chk("spurious_err", 64'(err), 64'd1);
        chk("spurious_pend", 64'(pending), 64'd0);

        // Writes during RUN and start during DRAIN are ignored.
        for (int i = 0; i < 16; i++) p[i] = mk(1'($urandom), rand_op());
        p[5] = mk(1'b1, 3'b100);
        load(p, 16);
        run(20, 1);
        run(0, 0);

        // Write and start in the same cycle; address 0 sees new data.
        step(1'b1, 4'd0, mk(1'b1, 3'b101), 1'b1, 1'b0, 1'b0);
        run_rest(0, 0);

        // Reset in the middle of a run, then rerun from address 0.
        step(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        idle_step();
        idle_step();
        idle_step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_iv", 64'(inst_v), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pend", 64'(pending), 64'd0);
        check_all();
        #2;
        rst_n = 1'b1;
        run(0, 0);

        // Random programs, stalls and pokes.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 16; i++) begin
                p[i] = mk(1'($urandom),
                          ($urandom_range(0, 9) == 0) ? 3'b100 : rand_op());
            end
            load(p, 16);
            run(int'($urandom_range(0, 40)), 1'($urandom));
            idle_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
